fetch: RTL and testbench

//   Instruction-fetch stage, directly upstream of decode. Owns the PC, issues one

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_pcselect.sv | 24 ++
 rtl/fetch.sv | 121 ++++++++++++
 tb/tb_fetch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: bus request/response, the
// fetch pipeline register and the fetch FSM states.
package fetch_pkg;

  typedef logic [63:0] word_t;

  localparam word_t PCINIT_DEFAULT = 64'h8000_0000;
  localparam word_t PC_STEP        = 64'd4;

  typedef struct packed {
    logic  valid;
    word_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    word_t       pc;
    logic [31:0] raw_instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_pcselect.sv
// Combinational next-PC mux for the fetch stage.
module fetch_pcselect
  import fetch_pkg::*;
(
  input  fetch_state_t state,
  input  logic         data_ok,
  input  logic         redir,
  input  word_t        pc,
  input  word_t        pcbranch,
  input  word_t        tgt,
  output word_t        pc_next
);

  always_comb begin
    pc_next = pc;
    case (state)
      FETCH:   if (data_ok) pc_next = redir ? pcbranch : pc + PC_STEP;
      HOLD:    if (redir)   pc_next = pcbranch;
      DISCARD: if (data_ok) pc_next = redir ? pcbranch : tgt;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one bus request at a time,
// buffers one instruction while stalled and produces dataF for decode.
module fetch
  import fetch_pkg::*;
#(
  parameter word_t PCINIT = PCINIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stopd,
  input  logic        stope,
  input  logic        stopm,
  input  logic        branch,
  input  word_t       pcbranch,
  output fetch_data_t dataF
);

  fetch_state_t state_reg, state_next;
  word_t        pc_reg, pc_next;
  word_t        tgt_reg, tgt_next;
  word_t        buf_pc_reg;
  logic [31:0]  buf_instr_reg;
  logic         buf_load;
  fetch_data_t  cand;
  fetch_data_t  dataF_next;
  logic         stall;
  logic         redir;
  logic         unused_addr_ok;

  assign unused_addr_ok = iresp.addr_ok;
  assign stall = stopd | stope | stopm;
  // Back-end stalls freeze the redirect; a decode bubble does not.
  assign redir = branch & ~(stope | stopm);

  always_comb begin
    ireq       = '0;
    ireq.valid = ~reset & (state_reg != HOLD);
    ireq.addr  = pc_reg;
  end

  fetch_pcselect u_pcselect (
    .state    (state_reg),
    .data_ok  (iresp.data_ok),
    .redir    (redir),
    .pc       (pc_reg),
    .pcbranch (pcbranch),
    .tgt      (tgt_reg),
    .pc_next  (pc_next)
  );

  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    buf_load   = 1'b0;
    cand       = '0;
    case (state_reg)
      FETCH: begin
        if (iresp.data_ok) begin
          if (!redir) begin
            if (stall) begin
              buf_load   = 1'b1;
              state_next = HOLD;
            end else begin
              cand = '{valid: 1'b1, pc: pc_reg, raw_instr: iresp.data};
            end
          end
        end else if (redir) begin
          tgt_next   = pcbranch;
          state_next = DISCARD;
        end
      end
      HOLD: begin
        if (redir) begin
          state_next = FETCH;
        end else if (!stall) begin
          cand       = '{valid: 1'b1, pc: buf_pc_reg, raw_instr: buf_instr_reg};
          state_next = FETCH;
        end
      end
      DISCARD: begin
        if (redir)         tgt_next   = pcbranch;
        if (iresp.data_ok) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    dataF_next = dataF;
    if (stope | stopm) begin
      dataF_next = dataF;
    end else if (redir) begin
      dataF_next.valid = 1'b0;
    end else if (!stopd) begin
      dataF_next = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FETCH;
      pc_reg        <= PCINIT;
      tgt_reg       <= '0;
      buf_pc_reg    <= '0;
      buf_instr_reg <= '0;
      dataF         <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      tgt_reg   <= tgt_next;
      dataF     <= dataF_next;
      if (buf_load) begin
        buf_pc_reg    <= pc_reg;
        buf_instr_reg <= iresp.data;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed, table-driven bench for the fetch stage plus hand-written reset sequences.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [63:0] P = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stopd, stope, stopm, branch;
  word_t       pcbranch;
  fetch_data_t dataF;

  int total = 0;
  int passed = 0;

  fetch #(.PCINIT(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .ireq     (ireq),
    .iresp    (iresp),
    .stopd    (stopd),
    .stope    (stope),
    .stopm    (stopm),
    .branch   (branch),
    .pcbranch (pcbranch),
    .dataF    (dataF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sd, se, sm, br;
    logic [63:0] pcb;
    logic        ok;
    logic [31:0] data;
    logic        e_rv;
    logic [63:0] e_ra;
    logic        e_dv;
    logic [63:0] e_dpc;
    logic [31:0] e_di;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sd, se, sm, br, input logic [63:0] pcb,
                     input logic ok, input logic [31:0] data,
                     input logic e_rv, input logic [63:0] e_ra,
                     input logic e_dv, input logic [63:0] e_dpc, input logic [31:0] e_di);
    vec_t v;
    v.sd = sd; v.se = se; v.sm = sm; v.br = br; v.pcb = pcb; v.ok = ok; v.data = data;
    v.e_rv = e_rv; v.e_ra = e_ra; v.e_dv = e_dv; v.e_dpc = e_dpc; v.e_di = e_di;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic sd, se, sm, br, input logic [63:0] pcb,
                       input logic ok, input logic [31:0] data);
    stopd = sd; stope = se; stopm = sm; branch = br; pcbranch = pcb;
    iresp.addr_ok = 1'b1; iresp.data_ok = ok; iresp.data = data;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 64'h0, 0, 32'h0);

    //  sd se sm br pcb                     ok data            rv addr                    dv dpc                     instr
    add(0, 0, 0, 0, 64'h0,                  1, 32'hA000_0000,  1, P,                      0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hA000_0001,  1, P + 64'h4,              1, P,                      32'hA000_0000);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hA000_0002,  1, P + 64'h8,              1, P + 64'h4,              32'hA000_0001);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          1, P + 64'hC,              1, P + 64'h8,              32'hA000_0002);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          1, P + 64'hC,              0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hB000_0000,  1, P + 64'hC,              0, 64'h0,                  32'h0);
    add(1, 0, 0, 0, 64'h0,                  1, 32'h0000_0013,  1, P + 64'h10,             1, P + 64'hC,              32'hB000_0000);
    add(1, 0, 0, 0, 64'h0,                  0, 32'h0,          0, 64'h0,                  1, P + 64'hC,              32'hB000_0000);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          0, 64'h0,                  1, P + 64'hC,              32'hB000_0000);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          1, P + 64'h14,             1, P + 64'h10,             32'h0000_0013);
    add(0, 0, 0, 1, P + 64'h100,            0, 32'h0,          1, P + 64'h14,             0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          1, P + 64'h14,             0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hDEAD_DEAD,  1, P + 64'h14,             0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hC000_0000,  1, P + 64'h100,            0, 64'h0,                  32'h0);
    add(0, 0, 0, 1, P + 64'h200,            1, 32'hBAD0_BAD0,  1, P + 64'h104,            1, P + 64'h100,            32'hC000_0000);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hC000_0001,  1, P + 64'h200,            0, 64'h0,                  32'h0);
    add(0, 1, 0, 1, P + 64'h300,            0, 32'h0,          1, P + 64'h204,            1, P + 64'h200,            32'hC000_0001);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          1, P + 64'h204,            1, P + 64'h200,            32'hC000_0001);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hC000_0002,  1, P + 64'h204,            0, 64'h0,                  32'h0);
    add(0, 0, 0, 1, P + 64'h400,            0, 32'h0,          1, P + 64'h208,            1, P + 64'h204,            32'hC000_0002);
    add(0, 0, 0, 1, P + 64'h500,            0, 32'h0,          1, P + 64'h208,            0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  1, 32'h1111_1111,  1, P + 64'h208,            0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hC000_0003,  1, P + 64'h500,            0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          1, P + 64'h504,            1, P + 64'h500,            32'hC000_0003);
    add(0, 0, 1, 0, 64'h0,                  1, 32'hC000_0004,  1, P + 64'h504,            0, 64'h0,                  32'h0);
    add(0, 0, 0, 1, P + 64'h600,            0, 32'h0,          0, 64'h0,                  0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hC000_0005,  1, P + 64'h600,            0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          1, P + 64'h604,            1, P + 64'h600,            32'hC000_0005);
    add(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h2222_2222, 1, P + 64'h604,            0, 64'h0,                  32'h0);
    add(0, 0, 0, 0, 64'h0,                  1, 32'hC000_0006,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,                 32'h0);
    add(0, 0, 0, 0, 64'h0,                  0, 32'h0,          1, 64'h0,                  1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hC000_0006);

    // Reset held for two edges; the request must stay low throughout.
    @(negedge clk); #1 check("reset_req_valid", 64'(ireq.valid), 64'h0);
    @(negedge clk); #1 check("reset_req_valid2", 64'(ireq.valid), 64'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(vq[i].sd, vq[i].se, vq[i].sm, vq[i].br, vq[i].pcb, vq[i].ok, vq[i].data);
      #1;
      check($sformatf("v%0d_req_valid", i), 64'(ireq.valid), 64'(vq[i].e_rv));
      if (vq[i].e_rv) check($sformatf("v%0d_req_addr", i), ireq.addr, vq[i].e_ra);
      check($sformatf("v%0d_dataF_valid", i), 64'(dataF.valid), 64'(vq[i].e_dv));
      if (vq[i].e_dv) begin
        check($sformatf("v%0d_dataF_pc", i), dataF.pc, vq[i].e_dpc);
        check($sformatf("v%0d_dataF_instr", i), 64'(dataF.raw_instr), 64'(vq[i].e_di));
      end
    end

    // Reset while DISCARD is waiting on the abandoned response.
    @(negedge clk); drive(0, 0, 0, 1, P + 64'h700, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    #1 check("discard_req_valid", 64'(ireq.valid), 64'h1);
    check("discard_req_addr", ireq.addr, 64'h0);
    reset = 1'b1;
    #1 check("discard_reset_req_low", 64'(ireq.valid), 64'h0);
    @(negedge clk); reset = 1'b0;
    #1 check("after_discard_reset_valid", 64'(ireq.valid), 64'h1);
    check("after_discard_reset_addr", ireq.addr, P);
    check("after_discard_reset_dataF", 64'(dataF.valid), 64'h0);

    // Reset while HOLD owns a buffered instruction; it must not surface afterwards.
    drive(1, 0, 0, 0, 64'h0, 1, 32'hC000_0007);
    @(negedge clk); drive(1, 0, 0, 0, 64'h0, 0, 32'h0);
    #1 check("hold_req_valid", 64'(ireq.valid), 64'h0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    #1 check("after_hold_reset_valid", 64'(ireq.valid), 64'h1);
    check("after_hold_reset_addr", ireq.addr, P);
    check("after_hold_reset_dataF", 64'(dataF.valid), 64'h0);
    @(negedge clk);
    #1 check("no_buffer_leak_dataF", 64'(dataF.valid), 64'h0);
    check("no_buffer_leak_addr", ireq.addr, P);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
